// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - three-digit BCD up/down counter with prescaler, start/stop toggle and clear
module bcd_counter #(
  parameter int DIV = 50000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_SS,
  input  logic       BTN_CLR,
  input  logic       UP,
  output logic [3:0] CNT1,
  output logic [3:0] CNT2,
  output logic [3:0] CNT3,
  output logic       RUN,
  output logic       CARRY
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic          ss_s1_q, ss_s2_q, ss_s3_q;
  logic          clr_s1_q, clr_s2_q;
  logic          run_q, run_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic          carry_q, carry_d;

  logic          ss_edge, tick;
  logic          w1, w2, w3;
  logic [3:0]    n1, n2, n3;

  // Returns {wrap, next_digit}; out-of-range codes are forced back into 0..9.
  function automatic logic [4:0] digit_step(input logic [3:0] d, input logic up);
    logic [4:0] r;
    if (up) begin
      if (d >= 4'd9) r = {1'b1, 4'd0};
      else           r = {1'b0, d + 4'd1};
    end else begin
      if (d == 4'd0)      r = {1'b1, 4'd9};
      else if (d > 4'd9)  r = {1'b0, 4'd9};
      else                r = {1'b0, d - 4'd1};
    end
    return r;
  endfunction

  always_comb begin
    ss_edge = ss_s2_q & ~ss_s3_q;
    tick    = run_q && (pre_q == PRE_MAX);

    {w1, n1} = digit_step(d1_q, UP);
    {w2, n2} = digit_step(d2_q, UP);
    {w3, n3} = digit_step(d3_q, UP);

    run_d   = run_q ^ ss_edge;
    pre_d   = pre_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    carry_d = 1'b0;

    if (clr_s2_q) begin
      pre_d = '0;
      d1_d  = 4'd0;
      d2_d  = 4'd0;
      d3_d  = 4'd0;
    end else begin
      if (run_q) pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        d1_d = n1;
        if (w1)       d2_d = n2;
        if (w1 && w2) d3_d = n3;
        carry_d = w1 & w2 & w3;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ss_s1_q  <= 1'b0;
      ss_s2_q  <= 1'b0;
      ss_s3_q  <= 1'b0;
      clr_s1_q <= 1'b0;
      clr_s2_q <= 1'b0;
      run_q    <= 1'b0;
      pre_q    <= '0;
      d1_q     <= 4'd0;
      d2_q     <= 4'd0;
      d3_q     <= 4'd0;
      carry_q  <= 1'b0;
    end else begin
      ss_s1_q  <= BTN_SS;
      ss_s2_q  <= ss_s1_q;
      ss_s3_q  <= ss_s2_q;
      clr_s1_q <= BTN_CLR;
      clr_s2_q <= clr_s1_q;
      run_q    <= run_d;
      pre_q    <= pre_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      d3_q     <= d3_d;
      carry_q  <= carry_d;
    end
  end

  assign CNT1  = d1_q;
  assign CNT2  = d2_q;
  assign CNT3  = d3_q;
  assign RUN   = run_q;
  assign CARRY = carry_q;

endmodule

// File: tb/tb_bcd_counter.sv
// tb/tb_bcd_counter.sv - directed table-driven bench for bcd_counter (DIV=4 and DIV=1 instances)
module tb_bcd_counter;

  logic clk = 1'b0;
  logic rst, ss, clr, up;

  logic [3:0] a1, a2, a3, b1, b2, b3;
  logic       a_run, a_carry, b_run, b_carry;

  int total = 0;
  int bad   = 0;

  bcd_counter #(.DIV(4)) u4 (
    .CLK(clk), .RST(rst), .BTN_SS(ss), .BTN_CLR(clr), .UP(up),
    .CNT1(a1), .CNT2(a2), .CNT3(a3), .RUN(a_run), .CARRY(a_carry)
  );

  bcd_counter #(.DIV(1)) u1 (
    .CLK(clk), .RST(rst), .BTN_SS(ss), .BTN_CLR(clr), .UP(up),
    .CNT1(b1), .CNT2(b2), .CNT3(b3), .RUN(b_run), .CARRY(b_carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ss, clr, up;
    int         n;
    logic [3:0] c3, c2, c1;
    logic       run, carry;
  } vec_t;

  vec_t tbl[20];

  function automatic logic [13:0] pk(input logic [3:0] c3, c2, c1, input logic r, c);
    return {c3, c2, c1, r, c};
  endfunction

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got cnt=%h%h%h run=%b carry=%b, want cnt=%h%h%h run=%b carry=%b",
               name, act[13:10], act[9:6], act[5:2], act[1], act[0],
               exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  int carries;

  initial begin
    tbl[0]  = '{1, 0, 1,  2, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 1,  1, 0, 0, 0, 1, 0};
    tbl[2]  = '{1, 0, 1,  3, 0, 0, 0, 1, 0};
    tbl[3]  = '{1, 0, 1,  1, 0, 0, 1, 1, 0};
    tbl[4]  = '{0, 0, 1, 36, 0, 1, 0, 1, 0};
    tbl[5]  = '{0, 0, 0,  4, 0, 0, 9, 1, 0};
    tbl[6]  = '{0, 0, 0,  3, 0, 0, 9, 1, 0};
    tbl[7]  = '{1, 0, 0,  1, 0, 0, 8, 1, 0};
    tbl[8]  = '{1, 0, 0,  1, 0, 0, 8, 1, 0};
    tbl[9]  = '{1, 0, 0,  1, 0, 0, 8, 0, 0};
    tbl[10] = '{0, 0, 0, 20, 0, 0, 8, 0, 0};
    tbl[11] = '{1, 0, 0,  3, 0, 0, 8, 1, 0};
    tbl[12] = '{1, 0, 0,  1, 0, 0, 8, 1, 0};
    tbl[13] = '{0, 0, 0,  1, 0, 0, 7, 1, 0};
    tbl[14] = '{0, 1, 0,  2, 0, 0, 7, 1, 0};
    tbl[15] = '{0, 1, 0,  1, 0, 0, 0, 1, 0};
    tbl[16] = '{0, 1, 0,  2, 0, 0, 0, 1, 0};
    tbl[17] = '{0, 0, 1,  5, 0, 0, 0, 1, 0};
    tbl[18] = '{0, 0, 1,  1, 0, 0, 1, 1, 0};
    tbl[19] = '{0, 0, 1, 16, 0, 0, 5, 1, 0};

    ss = 1'b0; clr = 1'b0; up = 1'b1; rst = 1'b1;
    #1;
    chk("async_reset_u4", pk(a3, a2, a1, a_run, a_carry), 14'd0);
    step(2);
    rst = 1'b0;
    chk("reset_u4", pk(a3, a2, a1, a_run, a_carry), 14'd0);
    chk("reset_u1", pk(b3, b2, b1, b_run, b_carry), 14'd0);

    for (int i = 0; i < 20; i++) begin
      ss  = tbl[i].ss;
      clr = tbl[i].clr;
      up  = tbl[i].up;
      step(tbl[i].n);
      chk($sformatf("vec%0d", i), pk(a3, a2, a1, a_run, a_carry),
          pk(tbl[i].c3, tbl[i].c2, tbl[i].c1, tbl[i].run, tbl[i].carry));
    end

    // Asynchronous reset mid-count, checked before the next clock edge.
    #2 rst = 1'b1;
    #1;
    chk("midcount_reset", pk(a3, a2, a1, a_run, a_carry), 14'd0);
    step(1);
    rst = 1'b0;

    do_reset();
    ss = 1'b1; up = 1'b1;
    step(3);
    chk("up_start_u1", pk(b3, b2, b1, b_run, b_carry), pk(0, 0, 0, 1, 0));
    carries = 0;
    for (int i = 0; i < 999; i++) begin
      step(1);
      if (b_carry) carries++;
    end
    chk("up_999", pk(b3, b2, b1, b_run, b_carry), pk(9, 9, 9, 1, 0));
    total++;
    if (carries != 0) begin
      bad++;
      $display("FAIL up_no_early_carry: got %0d carry pulses, want 0", carries);
    end
    step(1);
    chk("up_wrap", pk(b3, b2, b1, b_run, b_carry), pk(0, 0, 0, 1, 1));
    step(1);
    chk("up_after_wrap", pk(b3, b2, b1, b_run, b_carry), pk(0, 0, 1, 1, 0));

    up = 1'b0;
    do_reset();
    step(3);
    chk("down_start_u1", pk(b3, b2, b1, b_run, b_carry), pk(0, 0, 0, 1, 0));
    step(1);
    chk("down_wrap", pk(b3, b2, b1, b_run, b_carry), pk(9, 9, 9, 1, 1));
    step(1);
    chk("down_after_wrap", pk(b3, b2, b1, b_run, b_carry), pk(9, 9, 8, 1, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
